// File: rtl/regfile_writeback_queue.sv
// Register file writeback queue: merges ALU and load results into an in-order
// queue, drains one entry per cycle to the write port (r15 goes to the PC path),
// and offers bypass lookups over all queued entries.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alu_valid,
  input  logic [3:0]    alu_wa,
  input  logic [31:0]   alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [3:0]    mem_wa,
  input  logic [31:0]   mem_wd,
  output logic          we3,
  output logic [3:0]    wa3,
  output logic [31:0]   wd3,
  output logic          pc_wr_valid,
  output logic [31:0]   pc_wr_data,
  input  logic [3:0]    ra1,
  input  logic [3:0]    ra2,
  input  logic [3:0]    ra3,
  output logic          hit1,
  output logic          hit2,
  output logic          hit3,
  output logic [31:0]   bd1,
  output logic [31:0]   bd2,
  output logic [31:0]   bd3,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  PC_REG = 4'd15;

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t        slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop;
  logic [CW:0]   free;
  logic          alu_push;
  logic          mem_push;
  entry_t        head;

  logic [3:0]    ra  [3];
  logic          hit [3];
  logic [31:0]   bd  [3];
  logic [PW-1:0] idx;

  // Pop/free/push arbitration; ALU has priority and cannot be stalled
  always_comb begin
    pop       = (count != '0);
    free      = (CW + 1)'(DEPTH) - {1'b0, count} + (CW + 1)'(pop);
    alu_push  = alu_valid && (free != '0);
    mem_ready = (free >= ((CW + 1)'(1) + (CW + 1)'(alu_valid)));
    mem_push  = mem_valid && mem_ready;
  end

  // Queue storage, pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (alu_push) slots[wr_ptr] <= '{wa: alu_wa, wd: alu_wd};
      if (mem_push) slots[wr_ptr + PW'(alu_push)] <= '{wa: mem_wa, wd: mem_wd};
      wr_ptr <= wr_ptr + PW'(alu_push) + PW'(mem_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
      if (alu_valid && !alu_push) overflow <= 1'b1;
    end
  end

  // Head entry drives either the register file port or the PC update path
  always_comb begin
    head        = slots[rd_ptr];
    we3         = 1'b0;
    wa3         = '0;
    wd3         = '0;
    pc_wr_valid = 1'b0;
    pc_wr_data  = '0;
    if (pop) begin
      if (head.wa == PC_REG) begin
        pc_wr_valid = 1'b1;
        pc_wr_data  = head.wd;
      end else begin
        we3 = 1'b1;
        wa3 = head.wa;
        wd3 = head.wd;
      end
    end
  end

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;

  // Bypass search oldest to youngest so the youngest match wins; r15 never hits
  always_comb begin
    idx = '0;
    for (int k = 0; k < 3; k++) begin
      hit[k] = 1'b0;
      bd[k]  = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (slots[idx].wa == ra[k]) && (ra[k] != PC_REG)) begin
          hit[k] = 1'b1;
          bd[k]  = slots[idx].wd;
        end
      end
    end
  end

  assign hit1 = hit[0];
  assign hit2 = hit[1];
  assign hit3 = hit[2];
  assign bd1  = bd[0];
  assign bd2  = bd[1];
  assign bd3  = bd[2];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with a queue-based reference model
// checked on every falling edge, plus hand-computed literal expectations.
module tb_regfile_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, mem_valid, mem_ready;
  logic [3:0]    alu_wa, mem_wa, wa3;
  logic [31:0]   alu_wd, mem_wd, wd3, pc_wr_data;
  logic          we3, pc_wr_valid;
  logic [3:0]    ra1, ra2, ra3;
  logic          hit1, hit2, hit3;
  logic [31:0]   bd1, bd2, bd3;
  logic [CW-1:0] count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .hit1(hit1), .hit2(hit2), .hit3(hit3),
    .bd1(bd1), .bd2(bd2), .bd3(bd3),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending register writes
  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t model_q[$];
  bit   model_ovf = 0;

  function automatic void lookup(input logic [3:0] ra, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (ra != 4'd15)
      foreach (model_q[i])
        if (model_q[i].wa == ra) begin
          h = 1'b1;
          d = model_q[i].wd;
        end
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge
  always @(negedge clk) begin
    int          sz;
    int          free;
    bit          busy;
    logic        e_we, e_pc, h;
    logic [3:0]  e_wa;
    logic [31:0] e_wd, e_pcd, d;
    if (!reset_n) begin
      model_q.delete();
      model_ovf = 0;
    end
    sz    = model_q.size();
    busy  = (sz != 0);
    e_we  = 1'b0; e_pc = 1'b0; e_wa = '0; e_wd = '0; e_pcd = '0;
    if (busy) begin
      if (model_q[0].wa == 4'd15) begin
        e_pc  = 1'b1;
        e_pcd = model_q[0].wd;
      end else begin
        e_we = 1'b1;
        e_wa = model_q[0].wa;
        e_wd = model_q[0].wd;
      end
    end
    free = int'(DEPTH) - sz + (busy ? 1 : 0);
    chk("m_we3", 32'(we3), 32'(e_we));
    chk("m_wa3", 32'(wa3), 32'(e_wa));
    chk("m_wd3", wd3, e_wd);
    chk("m_pc_valid", 32'(pc_wr_valid), 32'(e_pc));
    chk("m_pc_data", pc_wr_data, e_pcd);
    chk("m_count", 32'(count), 32'(sz));
    chk("m_mem_ready", 32'(mem_ready), 32'(free >= 1 + (alu_valid ? 1 : 0)));
    chk("m_overflow", 32'(overflow), 32'(model_ovf));
    lookup(ra1, h, d); chk("m_hit1", 32'(hit1), 32'(h)); chk("m_bd1", bd1, d);
    lookup(ra2, h, d); chk("m_hit2", 32'(hit2), 32'(h)); chk("m_bd2", bd2, d);
    lookup(ra3, h, d); chk("m_hit3", 32'(hit3), 32'(h)); chk("m_bd3", bd3, d);
    if (reset_n) begin
      if (busy) void'(model_q.pop_front());
      if (alu_valid) begin
        if (free >= 1) model_q.push_back('{wa: alu_wa, wd: alu_wd});
        else model_ovf = 1;
      end
      if (mem_valid && (free >= 1 + (alu_valid ? 1 : 0)))
        model_q.push_back('{wa: mem_wa, wd: mem_wd});
    end
  end

  // Drive one cycle of producer inputs just after the rising edge
  task automatic cyc(input logic av, input logic [3:0] awa, input logic [31:0] awd,
                     input logic mv, input logic [3:0] mwa, input logic [31:0] mwd);
    @(posedge clk);
    #1;
    alu_valid = av; alu_wa = awa; alu_wd = awd;
    mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    ra1 = 4'd5; ra2 = 4'd6; ra3 = 4'd15;
    idle(2);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(1);

    // Single ALU write: visible next cycle, gone the cycle after
    cyc(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0);
    idle(1);
    @(negedge clk);
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_wa3", 32'(wa3), 32'd3);
    chk("alu_wd3", wd3, 32'h0000_00AA);
    chk("alu_count", 32'(count), 32'd1);
    idle(1);
    @(negedge clk);
    chk("alu_drained_we3", 32'(we3), 32'd0);
    chk("alu_drained_count", 32'(count), 32'd0);

    // ALU and load in the same cycle: ALU drains first
    cyc(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    @(negedge clk);
    chk("dual_mem_ready", 32'(mem_ready), 32'd1);
    idle(1);
    @(negedge clk);
    chk("dual_first_wa3", 32'(wa3), 32'd1);
    chk("dual_first_we3", 32'(we3), 32'd1);
    idle(1);
    @(negedge clk);
    chk("dual_second_wa3", 32'(wa3), 32'd2);
    chk("dual_second_wd3", wd3, 32'h22);
    idle(1);

    // Load to r15 goes to the PC path, not the register file
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h0000_0100);
    idle(1);
    @(negedge clk);
    chk("pc_valid", 32'(pc_wr_valid), 32'd1);
    chk("pc_data", pc_wr_data, 32'h0000_0100);
    chk("pc_we3", 32'(we3), 32'd0);
    chk("pc_hit3", 32'(hit3), 32'd0);
    idle(1);

    // Fill: ALU every cycle with a held load; occupancy saturates at DEPTH
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 4'(i + 1), 32'h100 + 32'(i), 1'b1, 4'(i + 8), 32'h200 + 32'(i));
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_mem_ready", 32'(mem_ready), 32'd0);
    chk("fill_overflow", 32'(overflow), 32'd0);
    idle(6);
    @(negedge clk);
    chk("fill_drained_count", 32'(count), 32'd0);

    // Two writes to r5 in one cycle: bypass returns the younger value
    cyc(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
    idle(1);
    @(negedge clk);
    chk("byp_hit1", 32'(hit1), 32'd1);
    chk("byp_bd1", bd1, 32'h2);
    chk("byp_hit2", 32'(hit2), 32'd0);
    chk("byp_hit3", 32'(hit3), 32'd0);
    idle(3);

    // Mid-operation reset discards three queued entries immediately
    cyc(1'b1, 4'd8, 32'h80, 1'b1, 4'd5, 32'h55);
    cyc(1'b1, 4'd9, 32'h90, 1'b1, 4'd10, 32'hA0);
    @(posedge clk);
    #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2;
    chk("prerst_count", 32'(count), 32'd3);
    chk("prerst_hit1", 32'(hit1), 32'd1);
    chk("prerst_bd1", bd1, 32'h55);
    reset_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_we3", 32'(we3), 32'd0);
    chk("async_hit1", 32'(hit1), 32'd0);
    idle(2);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(1);
    @(negedge clk);
    chk("post_rst_we3", 32'(we3), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    idle(3);
    @(negedge clk);
    chk("final_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
